// File: rtl/ram_access_arbiter_pkg.sv
// Shared types, constants and the byte-lane merge helper for the RAM access arbiter.
package ram_arb_pkg;

  localparam int unsigned ARB_N_PORTS = 2;
  localparam int unsigned ARB_ADDR_W  = 10;
  localparam int unsigned ARB_DATA_W  = 32;
  localparam int unsigned ARB_BE_W    = ARB_DATA_W / 8;
  localparam int unsigned WORD_OFFSET = 2;

  localparam logic [ARB_BE_W-1:0] BE_FULL = {ARB_BE_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    WR       = 3'd2,
    MERGE_WR = 3'd3,
    RESP     = 3'd4
  } state_t;

  typedef logic [$clog2(ARB_N_PORTS)-1:0] port_id_t;

  // Enabled lanes take the store data, the rest keep the word read from RAM.
  function automatic logic [ARB_DATA_W-1:0] merge_lanes(
    input logic [ARB_DATA_W-1:0] new_data,
    input logic [ARB_DATA_W-1:0] old_data,
    input logic [ARB_BE_W-1:0]   be
  );
    logic [ARB_DATA_W-1:0] merged;
    merged = old_data;
    for (int i = 0; i < int'(ARB_BE_W); i++) begin
      merged[i*8 +: 8] = be[i] ? new_data[i*8 +: 8] : old_data[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ram_access_arbiter_if.sv
// Requester-side bus of the RAM access arbiter: per-port request handshake and shared response.
interface ram_access_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int unsigned N_PORTS = ARB_N_PORTS,
  parameter int unsigned DATA_W  = ARB_DATA_W
);

  logic [N_PORTS-1:0]                REQ_VALID;
  logic [N_PORTS-1:0]                REQ_READY;
  logic [N_PORTS-1:0]                REQ_WRITE;
  logic [N_PORTS-1:0][31:0]          REQ_ADDR;
  logic [N_PORTS-1:0][DATA_W-1:0]    REQ_WDATA;
  logic [N_PORTS-1:0][DATA_W/8-1:0]  REQ_BE;
  logic [N_PORTS-1:0]                RSP_VALID;
  logic [DATA_W-1:0]                 RSP_RDATA;
  logic                              RSP_ERR;

  modport master (
    output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, REQ_BE,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR
  );

  modport slave (
    input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, REQ_BE,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR
  );

endinterface

// File: rtl/ram_access_arbiter_rr.sv
// Round-robin arbiter: one-hot grant from a request vector; priority rotates past the
// granted port whenever 'advance' pulses.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic [N-1:0] req_vec,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W-1:0] ptr_nxt_s;
  logic             found_s;

  // Scan ports in priority order starting at the pointer; first requester wins.
  always_comb begin
    grant     = '0;
    ptr_nxt_s = ptr_r;
    found_s   = 1'b0;
    for (int off = 0; off < int'(N); off++) begin
      for (int j = 0; j < int'(N); j++) begin
        if (!found_s && (j == ((int'(ptr_r) + off) % int'(N))) && req_vec[j]) begin
          grant[j]  = 1'b1;
          found_s   = 1'b1;
          ptr_nxt_s = PTR_W'((j + 1) % int'(N));
        end else begin
        end
      end
    end
  end

  // Priority pointer register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ptr_r <= '0;
    end else if (advance) begin
      ptr_r <= ptr_nxt_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares one single-port RAM between N_PORTS requesters, one transaction in flight.
// Optional high-address range check: define RAM_ARB_RANGE_CHECK_EN.
module ram_access_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned N_PORTS = ARB_N_PORTS,
  parameter int unsigned ADDR_W  = ARB_ADDR_W,
  parameter int unsigned DATA_W  = ARB_DATA_W
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  ram_access_arbiter_if.slave   bus,
  output logic                  RAM_ENABLE,
  output logic                  RAM_READ,
  output logic                  RAM_WRITE,
  output logic [ADDR_W-1:0]     RAM_ADDRESS,
  output logic [DATA_W-1:0]     RAM_DATA_IN,
  input  logic [DATA_W-1:0]     RAM_DATA_OUT
);

  localparam int unsigned BE_W = DATA_W / 8;

  state_t              state_r, state_nxt_s;
  logic [N_PORTS-1:0]  grant_s;
  logic                advance_s;
  logic                range_err_s;
  logic                unused_addr_s;

  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_wdata_s;
  logic [BE_W-1:0]     sel_be_s;
  logic                sel_write_s;
  port_id_t            sel_id_s;

  logic [ADDR_W-1:0]   addr_r, addr_nxt_s;
  logic [DATA_W-1:0]   wdata_r, wdata_nxt_s;
  logic [DATA_W-1:0]   rdata_r, rdata_nxt_s;
  logic [BE_W-1:0]     be_r, be_nxt_s;
  logic                write_r, write_nxt_s;
  logic                err_r, err_nxt_s;
  port_id_t            id_r, id_nxt_s;

  logic                ram_en_r, ram_en_s;
  logic                ram_rd_r, ram_rd_s;
  logic                ram_wr_r, ram_wr_s;
  logic [ADDR_W-1:0]   ram_addr_r, ram_addr_s;
  logic [DATA_W-1:0]   ram_din_r, ram_din_s;
  logic [N_PORTS-1:0]  rsp_valid_r, rsp_valid_s;
  logic [DATA_W-1:0]   rsp_rdata_r, rsp_rdata_s;
  logic                rsp_err_r, rsp_err_s;

  rr_arbiter #(.N(N_PORTS)) u_rr (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .req_vec (bus.REQ_VALID),
    .advance (advance_s),
    .grant   (grant_s)
  );

  assign bus.REQ_READY = (state_r == IDLE) ? grant_s : '0;
  assign unused_addr_s = ^bus.REQ_ADDR;

  // Payload mux driven by the one-hot grant.
  always_comb begin
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    sel_be_s    = '0;
    sel_write_s = 1'b0;
    sel_id_s    = '0;
    for (int i = 0; i < int'(N_PORTS); i++) begin
      if (grant_s[i]) begin
        sel_addr_s  = bus.REQ_ADDR[i][ADDR_W+WORD_OFFSET-1:WORD_OFFSET];
        sel_wdata_s = bus.REQ_WDATA[i];
        sel_be_s    = bus.REQ_BE[i];
        sel_write_s = bus.REQ_WRITE[i];
        sel_id_s    = port_id_t'(i);
      end else begin
      end
    end
  end

`ifdef RAM_ARB_RANGE_CHECK_EN
  // Any address bit above the RAM word range flags the granted request as out of range.
  always_comb begin
    range_err_s = 1'b0;
    for (int i = 0; i < int'(N_PORTS); i++) begin
      if (grant_s[i]) begin
        range_err_s = |bus.REQ_ADDR[i][31:ADDR_W+WORD_OFFSET];
      end else begin
      end
    end
  end
`else
  assign range_err_s = 1'b0;
`endif

  // Next state and next transaction context.
  always_comb begin
    state_nxt_s = state_r;
    advance_s   = 1'b0;
    addr_nxt_s  = addr_r;
    wdata_nxt_s = wdata_r;
    be_nxt_s    = be_r;
    write_nxt_s = write_r;
    id_nxt_s    = id_r;
    rdata_nxt_s = rdata_r;
    err_nxt_s   = err_r;
    case (state_r)
      IDLE: begin
        if (|grant_s) begin
          advance_s   = 1'b1;
          addr_nxt_s  = sel_addr_s;
          wdata_nxt_s = sel_wdata_s;
          be_nxt_s    = sel_be_s;
          write_nxt_s = sel_write_s;
          id_nxt_s    = sel_id_s;
          rdata_nxt_s = '0;
          err_nxt_s   = range_err_s;
          if (range_err_s) begin
            state_nxt_s = RESP;
          end else if (!sel_write_s) begin
            state_nxt_s = RD;
          end else if (sel_be_s == '0) begin
            state_nxt_s = RESP;
          end else if (sel_be_s == BE_FULL) begin
            state_nxt_s = WR;
          end else begin
            state_nxt_s = RD;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD: begin
        rdata_nxt_s = RAM_DATA_OUT;
        state_nxt_s = write_r ? MERGE_WR : RESP;
      end
      WR:       state_nxt_s = RESP;
      MERGE_WR: state_nxt_s = RESP;
      RESP:     state_nxt_s = IDLE;
      default:  state_nxt_s = IDLE;
    endcase
  end

  // Outputs decoded from the upcoming state so they can be registered without extra latency.
  always_comb begin
    ram_en_s    = 1'b0;
    ram_rd_s    = 1'b0;
    ram_wr_s    = 1'b0;
    ram_addr_s  = '0;
    ram_din_s   = '0;
    rsp_valid_s = '0;
    rsp_rdata_s = '0;
    rsp_err_s   = 1'b0;
    case (state_nxt_s)
      RD: begin
        ram_en_s   = 1'b1;
        ram_rd_s   = 1'b1;
        ram_addr_s = addr_nxt_s;
      end
      WR: begin
        ram_en_s   = 1'b1;
        ram_wr_s   = 1'b1;
        ram_addr_s = addr_nxt_s;
        ram_din_s  = wdata_nxt_s;
      end
      MERGE_WR: begin
        ram_en_s   = 1'b1;
        ram_wr_s   = 1'b1;
        ram_addr_s = addr_nxt_s;
        ram_din_s  = merge_lanes(wdata_nxt_s, rdata_nxt_s, be_nxt_s);
      end
      RESP: begin
        for (int i = 0; i < int'(N_PORTS); i++) begin
          rsp_valid_s[i] = (port_id_t'(i) == id_nxt_s);
        end
        rsp_rdata_s = (write_nxt_s || err_nxt_s) ? '0 : rdata_nxt_s;
        rsp_err_s   = err_nxt_s;
      end
      default: begin
      end
    endcase
  end

  // FSM state and latched transaction context.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r <= IDLE;
      addr_r  <= '0;
      wdata_r <= '0;
      be_r    <= '0;
      write_r <= 1'b0;
      id_r    <= '0;
      rdata_r <= '0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      addr_r  <= addr_nxt_s;
      wdata_r <= wdata_nxt_s;
      be_r    <= be_nxt_s;
      write_r <= write_nxt_s;
      id_r    <= id_nxt_s;
      rdata_r <= rdata_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  // Registered RAM strobes and response outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ram_en_r    <= 1'b0;
      ram_rd_r    <= 1'b0;
      ram_wr_r    <= 1'b0;
      ram_addr_r  <= '0;
      ram_din_r   <= '0;
      rsp_valid_r <= '0;
      rsp_rdata_r <= '0;
      rsp_err_r   <= 1'b0;
    end else begin
      ram_en_r    <= ram_en_s;
      ram_rd_r    <= ram_rd_s;
      ram_wr_r    <= ram_wr_s;
      ram_addr_r  <= ram_addr_s;
      ram_din_r   <= ram_din_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_rdata_r <= rsp_rdata_s;
      rsp_err_r   <= rsp_err_s;
    end
  end

  assign RAM_ENABLE    = ram_en_r;
  assign RAM_READ      = ram_rd_r;
  assign RAM_WRITE     = ram_wr_r;
  assign RAM_ADDRESS   = ram_addr_r;
  assign RAM_DATA_IN   = ram_din_r;
  assign bus.RSP_VALID = rsp_valid_r;
  assign bus.RSP_RDATA = rsp_rdata_r;
  assign bus.RSP_ERR   = rsp_err_r;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a behavioural 1024x32 RAM and a response scoreboard.
module tb_ram_access_arbiter;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        ram_enable, ram_read, ram_write;
  logic [9:0]  ram_address;
  logic [31:0] ram_data_in, ram_data_out;

  logic [31:0] mem [0:1023];
  bit          mem_loaded;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   en_cnt = 0;
  int   wr_cnt = 0;
  int   rw_both = 0;
  int   last_g = 1;

  ram_access_arbiter_if #(.N_PORTS(2), .DATA_W(32)) bus ();

  ram_access_arbiter dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .bus          (bus),
    .RAM_ENABLE   (ram_enable),
    .RAM_READ     (ram_read),
    .RAM_WRITE    (ram_write),
    .RAM_ADDRESS  (ram_address),
    .RAM_DATA_IN  (ram_data_in),
    .RAM_DATA_OUT (ram_data_out)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input int w);
    return 32'hC0DE_0000 | 32'(w);
  endfunction

  // Behavioural RAM: combinational read, write on clock edge.
  always @(posedge CLK) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
      mem_loaded <= 1'b1;
    end else if (ram_enable && ram_write) begin
      mem[ram_address] <= ram_data_in;
    end
  end

  assign ram_data_out = ram_enable ? mem[ram_address] : 32'h0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on every response pulse.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (ram_enable) en_cnt++;
      if (ram_enable && ram_write) wr_cnt++;
      if (ram_read && ram_write) rw_both++;
      if (bus.RSP_VALID != 2'b00) begin
        if (sb_q.size() == 0) begin
          check("rsp_unexpected", bus.RSP_VALID, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("rsp_port", bus.RSP_VALID, 2'b01 << e.port);
          check("rsp_rdata", bus.RSP_RDATA, e.rdata);
          check("rsp_err", bus.RSP_ERR, e.err);
          check("rsp_cycle", cyc, e.due);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_req(input int p, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] xr, input logic xe, input int lat, input bit push);
    bit   got;
    exp_t e;
    got = 1'b0;
    bus.REQ_WRITE[p] = wr;
    bus.REQ_ADDR[p]  = addr;
    bus.REQ_WDATA[p] = wdata;
    bus.REQ_BE[p]    = be;
    bus.REQ_VALID[p] = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge CLK);
      if (bus.REQ_READY[p]) begin
        got = 1'b1;
        last_g = p;
        if (push) begin
          e.port = p; e.rdata = xr; e.err = xe; e.due = cyc + lat;
          sb_q.push_back(e);
        end
      end
      @(posedge CLK);
      #1;
    end
    bus.REQ_VALID[p] = 1'b0;
    check("handshake", got, 1'b1);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb_q.size() != 0; k++) begin
      @(posedge CLK);
      #1;
    end
    check("drain", sb_q.size(), 0);
  endtask

  initial begin : stim
    int   base_cnt;
    int   ngr;
    int   granted;
    int   w;
    int   ntx [2];
    logic [1:0] gv;
    exp_t e;

    RESET_N = 1'b0;
    bus.REQ_VALID = '0; bus.REQ_WRITE = '0; bus.REQ_ADDR = '0;
    bus.REQ_WDATA = '0; bus.REQ_BE = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_ready", bus.REQ_READY, 0);
    check("rst_rsp_valid", bus.RSP_VALID, 0);
    check("rst_rsp_rdata", bus.RSP_RDATA, 0);
    check("rst_rsp_err", bus.RSP_ERR, 0);
    check("rst_ram_en", ram_enable, 0);
    check("rst_ram_rd", ram_read, 0);
    check("rst_ram_wr", ram_write, 0);
    check("rst_ram_addr", ram_address, 0);
    check("rst_ram_din", ram_data_in, 0);
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    @(posedge CLK); #1;

    // 1: full store then load of word 4
    base_cnt = wr_cnt;
    do_req(0, 1'b1, 32'h010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 2, 1'b1);
    drain();
    check("t1_write_count", wr_cnt - base_cnt, 1);
    check("t1_mem4", mem[4], 32'hDEAD_BEEF);
    do_req(0, 1'b0, 32'h010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 2, 1'b1);
    drain();

    // 2: partial store merges into word 4
    base_cnt = wr_cnt;
    do_req(1, 1'b1, 32'h010, 32'h0000_AA00, 4'b0010, 32'h0, 1'b0, 3, 1'b1);
    drain();
    check("t2_write_count", wr_cnt - base_cnt, 1);
    check("t2_mem4", mem[4], 32'hDEAD_AAEF);

    // 3: both ports continuously requesting loads
    ntx[0] = 0; ntx[1] = 0; ngr = 0;
    bus.REQ_WRITE = 2'b00;
    bus.REQ_ADDR[0] = 32'((32 + 0) * 4);
    bus.REQ_ADDR[1] = 32'((32 + 1) * 4);
    bus.REQ_VALID = 2'b11;
    for (int k = 0; k < 100 && ngr < 8; k++) begin
      @(negedge CLK);
      gv = bus.REQ_READY;
      granted = -1;
      if (gv != 2'b00) begin
        check("rr_onehot", $countones(gv), 1);
        check("rr_grant", gv, 2'b01 << (1 - last_g));
        granted = gv[1] ? 1 : 0;
        last_g = granted;
        w = 32 + 2 * ntx[granted] + granted;
        e.port = granted; e.rdata = pat(w); e.err = 1'b0; e.due = cyc + 2;
        sb_q.push_back(e);
        ntx[granted]++;
        ngr++;
      end
      @(posedge CLK); #1;
      if (granted >= 0) begin
        bus.REQ_ADDR[granted[0]] = 32'((32 + 2 * ntx[granted] + granted) * 4);
      end
    end
    bus.REQ_VALID = 2'b00;
    check("rr_grant_count", ngr, 8);
    drain();

    // 4: store with no byte enables never touches the RAM
    base_cnt = en_cnt;
    do_req(0, 1'b1, 32'h014, 32'h1234_5678, 4'h0, 32'h0, 1'b0, 1, 1'b1);
    drain();
    check("t4_no_enable", en_cnt - base_cnt, 0);
    check("t4_mem5", mem[5], pat(5));

    // 5: reset while the merged write is on the RAM port
    do_req(1, 1'b1, 32'h020, 32'h0000_0055, 4'b0001, 32'h0, 1'b0, 3, 1'b0);
    @(posedge CLK); #1;
    check("t5_in_merge", ram_write, 1'b1);
    RESET_N = 1'b0;
    #1;
    check("t5_rst_ram_wr", ram_write, 1'b0);
    check("t5_rst_rsp", bus.RSP_VALID, 0);
    repeat (2) @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    last_g = 1;
    @(posedge CLK); #1;
    check("t5_mem8", mem[8], pat(8));
    do_req(0, 1'b0, 32'h020, 32'h0, 4'h0, pat(8), 1'b0, 2, 1'b1);
    drain();

    // 6: address above the RAM range
    base_cnt = en_cnt;
`ifdef RAM_ARB_RANGE_CHECK_EN
    do_req(1, 1'b0, 32'h0000_1000, 32'h0, 4'h0, 32'h0, 1'b1, 1, 1'b1);
    drain();
    check("t6_no_enable", en_cnt - base_cnt, 0);
`else
    do_req(1, 1'b0, 32'h0000_1000, 32'h0, 4'h0, pat(0), 1'b0, 2, 1'b1);
    drain();
    check("t6_one_access", en_cnt - base_cnt, 1);
`endif

    repeat (3) @(posedge CLK);
    #1;
    check("rd_wr_exclusive", rw_both, 0);
    check("sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
